// File: rtl/seq_datapath_pkg.sv
// Shared encodings for the sequenced register/ALU datapath.
package seq_datapath_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    EXEC    = 3'd3,
    WB      = 3'd4
  } state_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: add, subtract, and, xor with carry/borrow and zero flags.
module dp_alu
  import seq_datapath_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0] sum_ext;

  always_comb begin
    sum_ext = '0;
    result  = '0;
    carry   = 1'b0;
    case (op)
      OP_ADD: begin
        sum_ext = {1'b0, a} + {1'b0, b};
        result  = sum_ext[WIDTH-1:0];
        carry   = sum_ext[WIDTH];
      end
      // The extension bit of an unsigned difference is set exactly when a < b.
      OP_SUB: begin
        sum_ext = {1'b0, a} - {1'b0, b};
        result  = sum_ext[WIDTH-1:0];
        carry   = sum_ext[WIDTH];
      end
      OP_AND:  result = a & b;
      default: result = a ^ b;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/seq_datapath.sv
// Register file plus 4-phase sequencer executing dst = reg[src_a] OP reg[src_b],
// with a start/ready handshake and an external register-load port.
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic [AW-1:0]    dst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             carry,
  output logic             zero
);

  state_t           state;
  logic [WIDTH-1:0] regs [NREGS];
  logic [1:0]       op_q;
  logic [AW-1:0]    src_a_q;
  logic [AW-1:0]    src_b_q;
  logic [AW-1:0]    dst_q;
  logic [WIDTH-1:0] dr_a;
  logic [WIDTH-1:0] dr_b;
  logic [WIDTH-1:0] ac;
  logic             ac_carry;
  logic             ac_zero;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero;

  dp_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (dr_a),
    .b      (dr_b),
    .op     (op_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      op_q      <= OP_ADD;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      dr_a      <= '0;
      dr_b      <= '0;
      ac        <= '0;
      ac_carry  <= 1'b0;
      ac_zero   <= 1'b0;
      out_data  <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        // An external write on the accepting edge lands before the operand fetches.
        IDLE: begin
          if (wr_en) regs[wr_addr] <= wr_data;
          if (start) begin
            op_q    <= op;
            src_a_q <= src_a;
            src_b_q <= src_b;
            dst_q   <= dst;
            state   <= FETCH_A;
          end
        end
        FETCH_A: begin
          dr_a  <= regs[src_a_q];
          state <= FETCH_B;
        end
        FETCH_B: begin
          dr_b  <= regs[src_b_q];
          state <= EXEC;
        end
        EXEC: begin
          ac       <= alu_result;
          ac_carry <= alu_carry;
          ac_zero  <= alu_zero;
          state    <= WB;
        end
        WB: begin
          regs[dst_q] <= ac;
          out_data    <= ac;
          carry       <= ac_carry;
          zero        <= ac_zero;
          out_valid   <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: a 4-bit/4-register instance against a behavioural model
// checked every cycle, plus an 8-bit/8-register instance with literal expectations.
module tb_seq_datapath;

  logic       clk = 1'b0;
  logic       rst;

  logic       a_start, a_ready, a_wr_en, a_out_valid, a_carry, a_zero;
  logic [1:0] a_op, a_src_a, a_src_b, a_dst, a_wr_addr;
  logic [3:0] a_wr_data, a_out_data;

  logic       b_start, b_ready, b_wr_en, b_out_valid, b_carry, b_zero;
  logic [1:0] b_op;
  logic [2:0] b_src_a, b_src_b, b_dst, b_wr_addr;
  logic [7:0] b_wr_data, b_out_data;

  always #5 clk = ~clk;

  seq_datapath #(.WIDTH(4), .NREGS(4)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .ready(a_ready), .op(a_op),
    .src_a(a_src_a), .src_b(a_src_b), .dst(a_dst), .wr_en(a_wr_en),
    .wr_addr(a_wr_addr), .wr_data(a_wr_data), .out_data(a_out_data),
    .out_valid(a_out_valid), .carry(a_carry), .zero(a_zero)
  );

  seq_datapath #(.WIDTH(8), .NREGS(8)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .ready(b_ready), .op(b_op),
    .src_a(b_src_a), .src_b(b_src_b), .dst(b_dst), .wr_en(b_wr_en),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .out_data(b_out_data),
    .out_valid(b_out_valid), .carry(b_carry), .zero(b_zero)
  );

  int total = 0;
  int passed = 0;

  // Behavioural model of instance A: register contents, one pending result, held outputs.
  int cyc = 0;
  bit model_ok = 0;
  int m_regs [4];
  int last_acc = -100;
  bit pend_active = 0;
  int pend_due, pend_dst, pend_data, pend_c, pend_z;
  int held_data = 0, held_c = 0, held_z = 0;
  int commit_cyc = -1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void model_alu(input int op, input int x, input int y,
                                    output int r, output int c);
    case (op)
      0: begin r = (x + y) % 16; c = (x + y >= 16) ? 1 : 0; end
      1: begin r = (x - y + 16) % 16; c = (x < y) ? 1 : 0; end
      2: begin r = x & y; c = 0; end
      default: begin r = x ^ y; c = 0; end
    endcase
  endfunction

  task automatic tick();
    bit rdy;
    int r, c;
    @(negedge clk);
    if (model_ok) begin
      chk("ready", int'(a_ready), (cyc >= last_acc + 4) ? 1 : 0);
      chk("out_valid", int'(a_out_valid), (commit_cyc == cyc) ? 1 : 0);
      chk("out_data", int'(a_out_data), held_data);
      chk("carry", int'(a_carry), held_c);
      chk("zero", int'(a_zero), held_z);
    end
    rdy = (cyc >= last_acc + 4);
    @(posedge clk);
    cyc++;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
      pend_active = 0;
      held_data = 0; held_c = 0; held_z = 0;
      commit_cyc = -1;
      last_acc = -100;
      model_ok = 1;
    end else if (model_ok) begin
      if (pend_active && cyc == pend_due) begin
        m_regs[pend_dst] = pend_data;
        held_data = pend_data; held_c = pend_c; held_z = pend_z;
        commit_cyc = cyc;
        pend_active = 0;
      end
      if (rdy) begin
        if (a_wr_en) m_regs[a_wr_addr] = int'(a_wr_data);
        if (a_start) begin
          model_alu(int'(a_op), m_regs[a_src_a], m_regs[a_src_b], r, c);
          pend_active = 1;
          pend_due = cyc + 4;
          pend_dst = int'(a_dst);
          pend_data = r; pend_c = c; pend_z = (r == 0) ? 1 : 0;
          last_acc = cyc;
        end
      end
    end
    #1;
  endtask

  task automatic a_wait_ready();
    int g = 0;
    while (cyc < last_acc + 4 && g < 20) begin tick(); g++; end
    if (g >= 20) chk("ready_timeout", 0, 1);
  endtask

  task automatic a_write(input int addr, input int data);
    a_wait_ready();
    a_wr_en = 1'b1; a_wr_addr = 2'(addr); a_wr_data = 4'(data);
    tick();
    a_wr_en = 1'b0;
  endtask

  task automatic a_run(input int op, input int sa, input int sb, input int d,
                       input bit wr, input int wa, input int wd, input bit noise,
                       output int res, output int c, output int z, output int v);
    a_wait_ready();
    a_start = 1'b1; a_op = 2'(op); a_src_a = 2'(sa); a_src_b = 2'(sb); a_dst = 2'(d);
    a_wr_en = wr; a_wr_addr = 2'(wa); a_wr_data = 4'(wd);
    tick();
    a_start = 1'b0; a_wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (noise) begin
        a_start = 1'($urandom_range(0, 1));
        a_wr_en = 1'($urandom_range(0, 1));
        a_op = 2'($urandom_range(0, 3));
        a_src_a = 2'($urandom_range(0, 3)); a_src_b = 2'($urandom_range(0, 3));
        a_dst = 2'($urandom_range(0, 3));
        a_wr_addr = 2'($urandom_range(0, 3)); a_wr_data = 4'($urandom_range(0, 15));
      end
      tick();
      a_start = 1'b0; a_wr_en = 1'b0;
    end
    res = int'(a_out_data); c = int'(a_carry); z = int'(a_zero); v = int'(a_out_valid);
  endtask

  task automatic a_op_chk(input string name, input int op, input int sa, input int sb,
                          input int d, input int er, input int ec, input int ez);
    int r, c, z, v;
    a_run(op, sa, sb, d, 0, 0, 0, 0, r, c, z, v);
    chk({name, "_valid"}, v, 1);
    chk({name, "_data"}, r, er);
    chk({name, "_carry"}, c, ec);
    chk({name, "_zero"}, z, ez);
  endtask

  task automatic b_write(input int addr, input int data);
    b_wr_en = 1'b1; b_wr_addr = 3'(addr); b_wr_data = 8'(data);
    tick();
    b_wr_en = 1'b0;
  endtask

  task automatic b_op_chk(input string name, input int op, input int sa, input int sb,
                          input int d, input int er, input int ec);
    b_start = 1'b1; b_op = 2'(op); b_src_a = 3'(sa); b_src_b = 3'(sb); b_dst = 3'(d);
    tick();
    b_start = 1'b0;
    chk({name, "_busy"}, int'(b_ready), 0);
    for (int i = 0; i < 3; i++) tick();
    chk({name, "_early"}, int'(b_out_valid), 0);
    tick();
    chk({name, "_valid"}, int'(b_out_valid), 1);
    chk({name, "_data"}, int'(b_out_data), er);
    chk({name, "_carry"}, int'(b_carry), ec);
    chk({name, "_zero"}, int'(b_zero), (er == 0) ? 1 : 0);
  endtask

  initial begin
    int r, c, z, v, vcount;
    rst = 1'b1;
    a_start = 0; a_op = 0; a_src_a = 0; a_src_b = 0; a_dst = 0;
    a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0;
    b_start = 0; b_op = 0; b_src_a = 0; b_src_b = 0; b_dst = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_ready", int'(a_ready), 1);
    chk("reset_out_data", int'(a_out_data), 0);
    chk("reset_out_valid", int'(a_out_valid), 0);

    a_write(0, 5); a_write(1, 3);
    a_op_chk("add_5_3", 0, 0, 1, 2, 8, 0, 0);
    a_op_chk("read_r2", 2, 2, 2, 2, 8, 0, 0);
    a_write(0, 9); a_write(1, 9);
    a_op_chk("add_9_9", 0, 0, 1, 2, 2, 1, 0);
    a_write(0, 3); a_write(1, 5);
    a_op_chk("sub_3_5", 1, 0, 1, 3, 14, 1, 0);
    a_op_chk("sub_5_3", 1, 1, 0, 3, 2, 0, 0);
    a_write(0, 7);
    a_op_chk("xor_self", 3, 0, 0, 0, 0, 0, 1);
    a_op_chk("read_r0", 2, 0, 0, 0, 0, 0, 1);
    a_write(0, 12); a_write(1, 10);
    a_op_chk("and_12_10", 2, 0, 1, 2, 8, 0, 0);

    // Busy-period start and r1=15 write must both be dropped.
    a_wait_ready();
    a_start = 1'b1; a_op = 2'(0); a_src_a = 2'(0); a_src_b = 2'(1); a_dst = 2'(2);
    tick();
    a_start = 1'b1; a_op = 2'(3); a_wr_en = 1'b1; a_wr_addr = 2'(1); a_wr_data = 4'(15);
    tick();
    a_start = 1'b0; a_wr_en = 1'b0;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin tick(); vcount += int'(a_out_valid); end
    chk("busy_one_pulse", vcount, 1);
    chk("busy_add_data", int'(a_out_data), 6);
    a_op_chk("busy_r1_kept", 2, 1, 1, 1, 10, 0, 0);

    a_run(0, 0, 0, 3, 1, 0, 6, 0, r, c, z, v);
    chk("wr_start_data", r, 12);
    chk("wr_start_valid", v, 1);

    // Reset while the sequencer sits in EXEC.
    a_wait_ready();
    a_start = 1'b1; a_op = 2'(0); a_src_a = 2'(0); a_src_b = 2'(1); a_dst = 2'(2);
    tick();
    a_start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_exec_ready", int'(a_ready), 1);
    chk("rst_exec_out", int'(a_out_data), 0);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin tick(); vcount += int'(a_out_valid); end
    chk("rst_exec_no_pulse", vcount, 0);
    for (int i = 0; i < 4; i++) a_op_chk("rst_reg_zero", 2, i, i, i, 0, 0, 1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0) a_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      a_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), r, c, z, v);
    end

    b_write(7, 200); b_write(6, 100);
    b_op_chk("b_add_200_100", 0, 7, 6, 5, 44, 1);
    b_op_chk("b_sub_100_200", 1, 6, 7, 4, 156, 1);
    b_op_chk("b_read_r7", 2, 7, 7, 3, 200, 0);
    b_op_chk("b_read_r5", 2, 5, 5, 2, 44, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
